// File: rtl/mdu_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_stall_ctrl: multiply/divide unit sequencer plus pipeline stall control
// for MDU hazards and load-use hazards. Optional macro MDU_DIV_EN adds div/divu.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mdu_stall_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IRD,
  input  logic [31:0] IRE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        MduStart,
  output logic [1:0]  MduOp,
  output logic        MduBusy
);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       start;

  logic [5:0] ire_op, ire_fn, ird_op, ird_fn;
  logic [4:0] ire_rt, ird_rs, ird_rt;
  logic       mul_e, div_e, start_e, div_d, use_d, load_e, load_use, mdu_stall;
  logic       unused_ok;

  assign ire_op = IRE[31:26];
  assign ire_fn = IRE[5:0];
  assign ire_rt = IRE[20:16];
  assign ird_op = IRD[31:26];
  assign ird_fn = IRD[5:0];
  assign ird_rs = IRD[25:21];
  assign ird_rt = IRD[20:16];

  // Fields the decoders never look at.
  assign unused_ok = ^{IRE[25:21], IRE[15:6], IRD[15:6], 4'(DIV_CYCLES)};

  assign mul_e = (ire_op == 6'b000000) && (ire_fn[5:1] == 5'b01100);
`ifdef MDU_DIV_EN
  assign div_e = (ire_op == 6'b000000) && (ire_fn[5:1] == 5'b01101);
  assign div_d = (ird_fn[5:1] == 5'b01101);
`else
  assign div_e = 1'b0;
  assign div_d = 1'b0;
`endif
  assign start_e = mul_e | div_e;

  // mult/multu, optional div/divu, and the HI/LO moves (0100xx) all touch the MDU.
  assign use_d = (ird_op == 6'b000000) &&
                 ((ird_fn[5:1] == 5'b01100) || div_d || (ird_fn[5:2] == 4'b0100));

  always_comb begin
    load_e = 1'b0;
    case (ire_op)
      6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100: load_e = 1'b1;
      default: load_e = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (start_e) begin
          start     = 1'b1;
          state_nxt = MUL;
          cnt_nxt   = 4'(MUL_CYCLES - 1);
`ifdef MDU_DIV_EN
          if (div_e) begin
            state_nxt = DIV;
            cnt_nxt   = 4'(DIV_CYCLES - 1);
          end
`endif
        end
      end
      default: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
    endcase
  end

  assign MduBusy  = (state != IDLE);
  // Start decodes straight from IRE, so it must be masked while reset is held.
  assign MduStart = start & reset;
  assign MduOp    = MduStart ? ire_fn[1:0] : 2'b00;

  assign load_use  = load_e && (ire_rt != 5'd0) && ((ire_rt == ird_rs) || (ire_rt == ird_rt));
  assign mdu_stall = use_d && (MduBusy || MduStart);

  assign StallF = reset & (mdu_stall | load_use);
  assign StallD = StallF;
  assign StallE = StallF;

endmodule
`default_nettype wire

// File: tb/tb_mdu_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdu_stall_ctrl: directed vectors with a queued scoreboard for mdu_stall_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mdu_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] IRD, IRE;
  logic        StallF, StallD, StallE, MduStart, MduBusy;
  logic [1:0]  MduOp;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0109_0018;
  localparam logic [31:0] MULTU = 32'h0109_0019;
  localparam logic [31:0] DIV   = 32'h0109_001A;
  localparam logic [31:0] DIVU  = 32'h0109_001B;
  localparam logic [31:0] MFLO  = 32'h0000_1012;
  localparam logic [31:0] MFHI  = 32'h0000_1810;
  localparam logic [31:0] LW8   = 32'h8C08_0000;
  localparam logic [31:0] LW0   = 32'h8C00_0000;
  localparam logic [31:0] LB5   = 32'h8005_0000;
  localparam logic [31:0] ADDU_RS8  = 32'h010A_4821;
  localparam logic [31:0] ADDU_RT8  = 32'h0148_4821;
  localparam logic [31:0] ADDU_OTH  = 32'h016C_4821;
  localparam logic [31:0] ADDU_ZERO = 32'h0000_4821;
  localparam logic [31:0] ADDU_RS5  = 32'h00A0_0821;

`ifdef MDU_DIV_EN
  localparam logic [31:0] LONG_OP = DIV;
  localparam logic [1:0]  LONG_FN = 2'b10;
`else
  localparam logic [31:0] LONG_OP = MULT;
  localparam logic [1:0]  LONG_FN = 2'b00;
`endif

  typedef struct {
    string      name;
    logic       stall;
    logic       start;
    logic [1:0] op;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mdu_stall_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .IRD(IRD), .IRE(IRE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .MduStart(MduStart), .MduOp(MduOp), .MduBusy(MduBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input string name, input logic rst_v, input logic [31:0] ird_v,
                      input logic [31:0] ire_v, input logic stall_v, input logic start_v,
                      input logic [1:0] op_v, input logic busy_v);
    exp_t e;
    @(posedge clk);
    #1;
    IRD   = ird_v;
    IRE   = ire_v;
    reset = rst_v;
    e.name = name; e.stall = stall_v; e.start = start_v; e.op = op_v; e.busy = busy_v;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        ok = (StallF === e.stall) && (StallD === e.stall) && (StallE === e.stall) &&
             (MduStart === e.start) && (MduBusy === e.busy) &&
             (!e.start || (MduOp === e.op));
        if (!ok) begin
          errors++;
          $display("FAIL %s: got FDE=%b%b%b start=%b op=%b busy=%b, expected stall=%b start=%b op=%b busy=%b",
                   e.name, StallF, StallD, StallE, MduStart, MduOp, MduBusy,
                   e.stall, e.start, e.op, e.busy);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    IRD   = NOP;
    IRE   = NOP;

    // Reset held: everything quiet even with hazards presented.
    step("rst_mult",  1'b0, MFHI, MULT, 0, 0, 2'b00, 0);
    step("rst_load",  1'b0, ADDU_RS8, LW8, 0, 0, 2'b00, 0);
    step("rel_idle",  1'b1, NOP, NOP, 0, 0, 2'b00, 0);

    // mult: one start cycle then five busy cycles.
    step("mult_start", 1'b1, NOP, MULT, 0, 1, 2'b00, 0);
    for (int i = 0; i < 5; i++) step("mult_busy", 1'b1, NOP, NOP, 0, 0, 2'b00, 1);
    step("mult_done", 1'b1, NOP, NOP, 0, 0, 2'b00, 0);

    // mult in EX with mfhi in decode the same cycle.
    step("mult_mfhi", 1'b1, MFHI, MULT, 1, 1, 2'b00, 0);
    for (int i = 0; i < 5; i++) step("mfhi_hold", 1'b1, MFHI, NOP, 1, 0, 2'b00, 1);
    step("mfhi_go",   1'b1, MFHI, NOP, 0, 0, 2'b00, 0);
    step("mfhi_ex",   1'b1, NOP, MFHI, 0, 0, 2'b00, 0);

    // multu encodes op 01.
    step("multu_start", 1'b1, NOP, MULTU, 0, 1, 2'b01, 0);
    for (int i = 0; i < 5; i++) step("multu_busy", 1'b1, NOP, NOP, 0, 0, 2'b00, 1);
    step("multu_done", 1'b1, NOP, NOP, 0, 0, 2'b00, 0);

    // Load-use hazards.
    step("lu_rs",     1'b1, ADDU_RS8, LW8, 1, 0, 2'b00, 0);
    step("lu_bubble", 1'b1, ADDU_RS8, NOP, 0, 0, 2'b00, 0);
    step("lu_other",  1'b1, ADDU_OTH, LW8, 0, 0, 2'b00, 0);
    step("lu_rt0",    1'b1, ADDU_ZERO, LW0, 0, 0, 2'b00, 0);
    step("lu_lb",     1'b1, ADDU_RS5, LB5, 1, 0, 2'b00, 0);
    step("lu_rt",     1'b1, ADDU_RT8, LW8, 1, 0, 2'b00, 0);
    step("nop_nop",   1'b1, NOP, NOP, 0, 0, 2'b00, 0);

`ifdef MDU_DIV_EN
    // divu, mflo arrives in decode next cycle: ten stall cycles, EX on cycle 12.
    step("divu_start", 1'b1, NOP, DIVU, 0, 1, 2'b11, 0);
    for (int i = 0; i < 10; i++) step("mflo_hold", 1'b1, MFLO, NOP, 1, 0, 2'b00, 1);
    step("mflo_go",   1'b1, MFLO, NOP, 0, 0, 2'b00, 0);
    step("mflo_ex",   1'b1, NOP, MFLO, 0, 0, 2'b00, 0);
`else
    // Without divide support div/divu are ordinary instructions.
    step("div_off",      1'b1, NOP, DIV, 0, 0, 2'b00, 0);
    step("div_off_idle", 1'b1, NOP, NOP, 0, 0, 2'b00, 0);
    step("mflo_idle",    1'b1, MFLO, NOP, 0, 0, 2'b00, 0);
    step("mult_divu_d",  1'b1, DIVU, MULT, 0, 1, 2'b00, 0);
    for (int i = 0; i < 5; i++) step("divu_d_nostall", 1'b1, DIVU, NOP, 0, 0, 2'b00, 1);
    step("divu_d_idle",  1'b1, DIVU, NOP, 0, 0, 2'b00, 0);
`endif

    // Asynchronous reset three cycles into a long operation.
    step("long_start", 1'b1, NOP, LONG_OP, 0, 1, LONG_FN, 0);
    step("long_busy1", 1'b1, MFLO, NOP, 1, 0, 2'b00, 1);
    step("long_busy2", 1'b1, MFLO, NOP, 1, 0, 2'b00, 1);
    step("async_rst",  1'b0, MFLO, NOP, 0, 0, 2'b00, 0);
    step("post_rst",   1'b1, MFLO, NOP, 0, 0, 2'b00, 0);
    step("post_rst_mult", 1'b1, NOP, MULT, 0, 1, 2'b00, 0);
    step("post_rst_busy", 1'b1, NOP, NOP, 0, 0, 2'b00, 1);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending vectors, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_stall_ctrl.md
MDU_STALL_CTRL -- requirements
Module: mdu_stall_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy cycles for mult/multu (range 2..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu (range 2..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IRD  input  32  instruction word in the decode stage.
REQ-006 SHALL have port IRE  input  32  instruction word in the execute stage (ID_EX output).
REQ-007 SHALL have port StallF  output  1  hold the PC.
REQ-008 SHALL have port StallD  output  1  hold the IF_ID register.
REQ-009 SHALL have port StallE  output  1  insert a bubble into ID_EX (IR and PC4 cleared).
REQ-010 SHALL have port MduStart  output  1  one-cycle pulse launching the multiply/divide unit.
REQ-011 SHALL have port MduOp  output  2  operation at start: 00 mult, 01 multu, 10 div, 11 divu.
REQ-012 SHALL have port MduBusy  output  1  the multiply/divide unit is computing.

Function
REQ-013 SHALL decode an MDU start instruction as opcode 000000 with funct 011000/011001/011010/011011 (mult/multu/div/divu).
REQ-014 SHALL decode an MDU-use instruction in IRD as an MDU start instruction or funct 010000/010010/010001/010011 (mfhi/mflo/mthi/mtlo), opcode 000000.
REQ-015 SHALL implement the FSM states IDLE, MUL and DIV, with 4-bit down-counter cnt.
REQ-016 SHALL, in IDLE with an MDU start instruction in IRE, assert MduStart combinationally with MduOp = funct[1:0], then go to MUL (mult/multu) or DIV (div/divu) with cnt loaded to MUL_CYCLES-1 or DIV_CYCLES-1.
REQ-017 SHALL, in MUL/DIV, decrement cnt each cycle and return to IDLE on the edge where cnt = 0; busy time is exactly MUL_CYCLES or DIV_CYCLES cycles after the start cycle.
REQ-018 SHALL drive MduBusy = 1 exactly while state is MUL or DIV.
REQ-019 SHALL never assert MduStart outside IDLE; a start instruction in IRE while busy cannot occur, because REQ-020 holds it in decode.
REQ-020 SHALL assert the MDU stall when IRD is an MDU-use instruction and (MduBusy or MduStart) is 1.
REQ-021 SHALL assert the load-use stall when IRE opcode is lw/lh/lhu/lb/lbu, IRE rt is not 0, and IRE rt equals IRD rs or IRD rt.
REQ-022 SHALL drive StallF = StallD = StallE = (MDU stall OR load-use stall), combinationally, with no cycle of latency.
REQ-023 SHALL, in the cycle after a stall, see IRE = 0 (bubble), so a load-use stall lasts exactly one cycle.
REQ-024 SHALL keep an MDU stall asserted until the cycle after the FSM returns to IDLE; the stalled instruction then advances.
REQ-025 SHALL treat IRE = 0 (nop/bubble) as neither a start instruction nor a load.

Reset
REQ-026 SHALL, while reset = 0, force state IDLE and cnt = 0, asynchronously, including mid-operation.
REQ-027 SHALL hold MduStart = 0, MduBusy = 0 and all stalls = 0 during reset, regardless of IRD/IRE.
REQ-028 SHALL leave IDLE only on the first rising clk edge after reset deasserts.

Configuration
REQ-029 SHALL, with macro MDU_DIV_EN defined, support div/divu as specified above.
REQ-030 SHALL, without MDU_DIV_EN, omit the DIV state and DIV_CYCLES logic; div/divu SHALL not be start instructions or MDU-use instructions (no MduStart, no stall).

Verification
REQ-031 SHALL cover: IRE=mult $t0,$t1 in IDLE -> MduStart=1 and MduOp=00 for 1 cycle, MduBusy=1 for 5 cycles, then 0.
REQ-032 SHALL cover: IRE=divu, then IRD=mflo on the next cycle -> stalls=1 for 10 cycles; mflo enters EX on cycle 12 after the start (MDU_DIV_EN defined).
REQ-033 SHALL cover: IRE=lw $8,0($0) and IRD=addu $9,$8,$10 -> stalls=1 for one cycle; no stall for rt=$0 or for unrelated registers.
REQ-034 SHALL cover: IRE=mult and IRD=mfhi in the same cycle -> MduStart=1 and stalls=1 in that cycle.
REQ-035 SHALL cover: reset pulled low 3 cycles into a div -> MduBusy=0 and stalls=0 immediately, with no clock edge needed.
REQ-036 SHALL cover: MDU_DIV_EN undefined, IRE=div -> MduStart=0 and MduBusy=0; IRD=mflo with an idle MDU -> no stall.
